// File: rtl/prog_launcher_if.sv
// Launcher <-> harness/core signal bundle.
// The master modport is the launcher side: it samples Go and Done and drives
// the Start pulse plus the status/measurement outputs. The slave modport is
// the harness/core side.
interface prog_launcher_if #(
  parameter int CW = 16
);
  logic          Go;
  logic          Done;
  logic          Start;
  logic [1:0]    ProgIdx;
  logic          Busy;
  logic          AllDone;
  logic          TimedOut;
  logic [CW-1:0] CycleCount;

  modport master (
    input  Go,
    input  Done,
    output Start,
    output ProgIdx,
    output Busy,
    output AllDone,
    output TimedOut,
    output CycleCount
  );

  modport slave (
    output Go,
    output Done,
    input  Start,
    input  ProgIdx,
    input  Busy,
    input  AllDone,
    input  TimedOut,
    input  CycleCount
  );
endinterface

// File: rtl/prog_launcher.sv
// prog_launcher: initiator side of the core's Start/Done handshake.
// On Go (sampled only while idle) it launches programs 1..NUM_PROGS in turn:
// each launch is a START_HOLD-cycle Start pulse, followed by GUARD cycles in
// which Done is ignored (the previous program's Done may still be high), then
// a wait for Done. The run length from Start fall to Done is reported on
// CycleCount.
//
// Handshake: Start is a level pulse the core sees as a rising edge; Done is a
// level from the core and is only honoured in WAIT_DONE. Go is a level that is
// sampled once per clock while idle; Go and Done together in IDLE -> Go wins.
//
// Optional watchdog: define PROG_LAUNCHER_TIMEOUT_EN to abort a program whose
// run counter reaches TIMEOUT without Done (TimedOut is sticky until next Go).
// Without the macro TimedOut stays 0 and WAIT_DONE waits indefinitely.
//
// DbgState exposes the FSM state (IDLE=0, START_HI=1, GUARD=2, WAIT_DONE=3).
module prog_launcher #(
  parameter int NUM_PROGS  = 3,
  parameter int START_HOLD = 2,
  parameter int GUARD      = 2,
  parameter int CW         = 16
`ifdef PROG_LAUNCHER_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 4000
`endif
) (
  input  logic              Clk,
  input  logic              Reset_n,
  prog_launcher_if.master   bus,
  output logic [1:0]        DbgState
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START_HI  = 2'd1,
    S_GUARD     = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(START_HOLD - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);
  localparam logic [1:0]    LAST_IDX   = 2'(NUM_PROGS);
  localparam logic [CW-1:0] RUN_MAX    = '1;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] guard_cnt;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_inc;

  // Run counter next value, saturating so a very long run reads as all-ones.
  always_comb begin
    run_inc = run_cnt;
    if (run_cnt != RUN_MAX) run_inc = run_cnt + CW'(1);
  end

  assign DbgState = state;

  // Launch sequencer: one Start pulse per program, guard window, wait for Done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state          <= S_IDLE;
      hold_cnt       <= '0;
      guard_cnt      <= '0;
      run_cnt        <= '0;
      bus.Start      <= 1'b0;
      bus.ProgIdx    <= 2'd0;
      bus.Busy       <= 1'b0;
      bus.AllDone    <= 1'b0;
      bus.TimedOut   <= 1'b0;
      bus.CycleCount <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Go) begin
            bus.Start      <= 1'b1;
            bus.ProgIdx    <= 2'd1;
            bus.Busy       <= 1'b1;
            bus.AllDone    <= 1'b0;
            bus.TimedOut   <= 1'b0;
            bus.CycleCount <= '0;
            hold_cnt       <= '0;
            state          <= S_START_HI;
          end
        end

        S_START_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            // Start falls here; the run is measured from this edge.
            bus.Start <= 1'b0;
            run_cnt   <= '0;
            guard_cnt <= '0;
            state     <= S_GUARD;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        S_GUARD: begin
          // Done is deliberately not looked at: it may be the stale level
          // left over from the previous program.
          run_cnt <= run_inc;
          if (guard_cnt == GUARD_LAST) begin
            state <= S_WAIT_DONE;
          end else begin
            guard_cnt <= guard_cnt + GW'(1);
          end
        end

        S_WAIT_DONE: begin
          run_cnt <= run_inc;
          if (bus.Done) begin
            bus.CycleCount <= run_cnt;
            if (bus.ProgIdx == LAST_IDX) begin
              bus.Busy    <= 1'b0;
              bus.AllDone <= 1'b1;
              bus.ProgIdx <= 2'd0;
              state       <= S_IDLE;
            end else begin
              // Start was low last cycle, so the core sees a clean rising edge.
              bus.ProgIdx <= bus.ProgIdx + 2'd1;
              bus.Start   <= 1'b1;
              hold_cnt    <= '0;
              state       <= S_START_HI;
            end
          end
`ifdef PROG_LAUNCHER_TIMEOUT_EN
          else if (run_cnt == CW'(TIMEOUT)) begin
            // ProgIdx is left pointing at the program that never finished.
            bus.TimedOut   <= 1'b1;
            bus.Busy       <= 1'b0;
            bus.AllDone    <= 1'b0;
            bus.CycleCount <= CW'(TIMEOUT);
            state          <= S_IDLE;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
// Self-checking bench for prog_launcher.
// A core model answers each Start pulse with a randomly timed Done (optionally
// leaving the previous Done high for a few cycles); at every launch it pushes
// the expected status word into exp_q. A monitor pops and compares whenever the
// launcher presents an event (Start rising or Busy falling).
// Build with +define+PROG_LAUNCHER_TIMEOUT_EN to also run the watchdog series.
module tb_prog_launcher;

  localparam int NUM_PROGS  = 3;
  localparam int START_HOLD = 2;
  localparam int GUARD      = 2;
  localparam int CW         = 16;
  localparam int TIMEOUT    = 50;
  localparam int EW         = 6 + CW;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] DbgState;

  prog_launcher_if #(.CW(CW)) bus ();

  prog_launcher #(
    .NUM_PROGS (NUM_PROGS),
    .START_HOLD(START_HOLD),
    .GUARD     (GUARD),
    .CW        (CW)
`ifdef PROG_LAUNCHER_TIMEOUT_EN
    ,
    .TIMEOUT   (TIMEOUT)
`endif
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus),
    .DbgState(DbgState)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int go_tag      = 0;  // bumped on every Go the bench issues
  int kill_prog   = 0;  // program index whose Done never comes (0 = none)
  int fixed_delay = 0;  // nonzero: Done rises exactly this many cycles after Start fall

  // Status word: {Start, ProgIdx, Busy, AllDone, TimedOut, CycleCount}
  function automatic logic [EW-1:0] pack(input logic st, input int idx, input logic b,
                                         input logic ad, input logic to, input int cc);
    return {st, idx[1:0], b, ad, to, cc[CW-1:0]};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {bus.Start, bus.ProgIdx, bus.Busy, bus.AllDone, bus.TimedOut, bus.CycleCount};
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- core model (drives Done) ----------------
  initial begin
    int  k, c, stale, dly, seen_tag, exp_cc;
    bit  prev_st, counting;
    k = 0; c = 0; stale = 0; dly = 0; seen_tag = 0; prev_st = 0; counting = 0;
    bus.Done = 1'b0;
    forever begin
      @(posedge Clk); #1;
      if (!Reset_n) begin
        k = 0; prev_st = 0; counting = 0; bus.Done = 1'b0;
        continue;
      end
      if (bus.Start && !prev_st) begin
        if (seen_tag != go_tag) begin
          seen_tag = go_tag;
          k = 0;
        end
        k++;
        stale = bus.Done ? int'($urandom_range(0, 4)) : 0;
        dly   = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 14));
        if (k == kill_prog) begin
          stale = 0;
          dly   = 1 << 20;
        end
        if (stale == 0) bus.Done = 1'b0;
        counting = 0;
        // Completion is the first cycle c >= GUARD after Start fall with Done high,
        // where Done is high for c < stale and for c >= dly.
        if (stale > GUARD) exp_cc = GUARD;
        else exp_cc = (dly > GUARD) ? dly : GUARD;
        if (k == kill_prog)      exp_q.push_back(pack(1'b0, k, 1'b0, 1'b0, 1'b1, TIMEOUT));
        else if (k < NUM_PROGS)  exp_q.push_back(pack(1'b1, k + 1, 1'b1, 1'b0, 1'b0, exp_cc));
        else                     exp_q.push_back(pack(1'b0, 0, 1'b0, 1'b1, 1'b0, exp_cc));
      end
      if (!bus.Start && prev_st) begin
        c = 0;
        counting = 1;
      end else if (counting) begin
        c++;
      end
      if (counting) bus.Done = (c < stale) || (c >= dly);
      prev_st = bus.Start;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit prev_st, prev_busy, seen_fall;
    int width, gap;
    prev_st = 0; prev_busy = 0; seen_fall = 0; width = 0; gap = 0;
    forever begin
      @(posedge Clk); #1;
      if (!Reset_n) begin
        prev_st = 0; prev_busy = 0; seen_fall = 0; width = 0; gap = 0;
        exp_q.delete();
        continue;
      end
      if ((bus.Start && !prev_st) || (!bus.Busy && prev_busy)) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_event: got %0h expected no event at %0t", obs(), $time);
        end else begin
          check_val("event", 64'(obs()), 64'(exp_q.pop_front()));
        end
      end
      if (bus.Start && !prev_st) begin
        if (seen_fall) begin
          total_cnt++;
          if (gap >= GUARD + 1) pass_cnt++;
          else $display("FAIL start_gap: got %0d low cycles required >= %0d at %0t",
                        gap, GUARD + 1, $time);
        end
        gap = 0;
      end
      if (!bus.Start && prev_st) begin
        check_val("start_width", 64'(width), 64'(START_HOLD));
        width = 0;
        seen_fall = 1;
      end
      if (bus.Start) width++;
      else gap++;
      prev_st   = bus.Start;
      prev_busy = bus.Busy;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1 with the launcher idle.
  task automatic issue_go();
    bus.Go = 1'b1;
    go_tag++;
    exp_q.push_back(pack(1'b1, 1, 1'b1, 1'b0, 1'b0, 0));
  endtask

  // Waits (bounded) for Busy to fall; optionally toggles Go while busy.
  task automatic wait_series_end(input bit pulse_go);
    bit ended;
    ended = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge Clk); #1;
      if (!bus.Busy) begin
        bus.Go = 1'b0;
        ended = 1;
        break;
      end
      bus.Go = pulse_go ? ($urandom_range(0, 4) == 0) : 1'b0;
    end
    if (!ended) begin
      bus.Go = 1'b0;
      total_cnt++;
      $display("FAIL series_end: Busy still %0b after 3000 cycles at %0t", bus.Busy, $time);
    end
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 3)) begin
      @(posedge Clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    bus.Go = 1'b1;
    Reset_n = 1'b0;

    // Reset with Go held high: everything zero.
    repeat (3) @(posedge Clk);
    #1;
    check_val("reset_outputs", 64'(obs()), 64'(pack(1'b0, 0, 1'b0, 1'b0, 1'b0, 0)));
    check_val("reset_state_idle", 64'(DbgState), 64'd0);

    // Release with Go still high: sampled at the very next edge.
    @(negedge Clk);
    Reset_n = 1'b1;
    go_tag++;
    fixed_delay = 10;
    exp_q.push_back(pack(1'b1, 1, 1'b1, 1'b0, 1'b0, 0));
    wait_series_end(1'b0);
    fixed_delay = 0;

    // Random series, with stray Go pulses while busy.
    for (int s = 0; s < 8; s++) begin
      idle_gap();
      issue_go();
      wait_series_end(1'b1);
    end

    // Reset during program 2's Start pulse.
    idle_gap();
    issue_go();
    found = 0;
    for (int n = 0; n < 500; n++) begin
      @(posedge Clk); #1;
      bus.Go = 1'b0;
      if (bus.Start && bus.ProgIdx == 2'd2) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      total_cnt++;
      $display("FAIL find_prog2_start: got ProgIdx %0d Start %0b expected 2/1", bus.ProgIdx, bus.Start);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("reset_mid_series", 64'(obs()), 64'(pack(1'b0, 0, 1'b0, 1'b0, 1'b0, 0)));
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;
    issue_go();
    wait_series_end(1'b1);

`ifdef PROG_LAUNCHER_TIMEOUT_EN
    // Program 2 never finishes: watchdog fires, then a normal series follows.
    idle_gap();
    kill_prog = 2;
    issue_go();
    wait_series_end(1'b0);
    kill_prog = 0;
    repeat (5) @(posedge Clk);
    #1;
    issue_go();
    wait_series_end(1'b1);
`endif

    repeat (20) @(posedge Clk);
    #1;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL leftover_expected: got %0d pending entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
